// File: rtl/fxp_mul_sequencer_if.sv
// Operand/result handshake bundle for fxp_mul_sequencer.
// master = producer/consumer side (neuron control), slave = the sequencer.
interface fxp_mul_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_accum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_accum, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_accum, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/fxp_mul_sequencer.sv
// Q16.16 x Q16.16 multiply(-accumulate) built from four passes through one
// shared 16x16 signed multiplier: high*high, high*frac, frac*high, frac*frac.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// HH    | acc += (Ah*Bh) << 16
// HF    | acc += (Ah*Bf) << 1
// FH    | acc += (Af*Bh) << 1
// FF    | acc += (Af*Bf) >>> 14, result/overflow registered
// OUT   | out_valid high until out_ready
module fxp_mul_sequencer #(
  parameter int ACC_W  = 48,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  fxp_mul_sequencer_if.slave  bus,
  output logic signed [15:0]  mul_dataa,
  output logic signed [15:0]  mul_datab,
  input  logic signed [31:0]  mul_result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HH   = 3'd1,
    HF   = 3'd2,
    FH   = 3'd3,
    FF   = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_n;

  logic [31:0]             a_q, b_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_sum;
  logic [31:0]             res_q;
  logic                    ovf_q;

  logic signed [15:0] a_hi, b_hi, a_fr, b_fr;
  logic [ACC_W-32:0]  acc_top;
  logic               sum_ovf;
  logic [31:0]        sum_res;

  // Fraction halves are Q0.15 with bit 0 of the operand discarded.
  assign a_hi = a_q[31:16];
  assign b_hi = b_q[31:16];
  assign a_fr = 16'(a_q[15:0] >> 1);
  assign b_fr = 16'(b_q[15:0] >> 1);

  assign p_ext   = {{(ACC_W-32){mul_result[31]}}, mul_result};
  assign acc_sum = acc + addend;

  // In range for 32 bits only when bits [ACC_W-1:31] are all sign copies.
  assign acc_top = acc_sum[ACC_W-1:31];
  assign sum_ovf = !((&acc_top) || (~|acc_top));

  always_comb begin
    sum_res = acc_sum[31:0];
    if (SAT_EN && sum_ovf)
      sum_res = acc_sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_comb begin
    state_n       = state;
    mul_dataa     = '0;
    mul_datab     = '0;
    addend        = '0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = reset_n;
        if (bus.in_valid)
          state_n = HH;
      end
      HH: begin
        mul_dataa = a_hi;
        mul_datab = b_hi;
        addend    = p_ext <<< 16;
        state_n   = HF;
      end
      HF: begin
        mul_dataa = a_hi;
        mul_datab = b_fr;
        addend    = p_ext <<< 1;
        state_n   = FH;
      end
      FH: begin
        mul_dataa = a_fr;
        mul_datab = b_hi;
        addend    = p_ext <<< 1;
        state_n   = FF;
      end
      FF: begin
        mul_dataa = a_fr;
        mul_datab = b_fr;
        addend    = p_ext >>> 14;
        state_n   = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // acc survives OUT so a following in_accum=1 operation can build on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
            if (!bus.in_accum)
              acc <= '0;
          end
        end
        HH, HF, FH: acc <= acc_sum;
        FF: begin
          acc   <= acc_sum;
          res_q <= sum_res;
          ovf_q <= sum_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result = res_q;
  assign bus.out_ovf    = ovf_q;

endmodule
